sid_filter_ctrl: RTL and testbench
==================================

SID_FILTER_CTRL -- requirements
Module: sid_filter_ctrl

Interface
REQ-001 Parameter SAMPLE_DIV, default 1: number of qualified tick pulses per filter sample (range 1..255).
REQ-002 Parameter FILT_LAT, default 12: wait cycles between input_valid and sound capture (range 12..63).
REQ-003 clk  in  1  system clock; all logic on rising edge; one clock only.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 tick  in  1  one-cycle sample-rate enable (phi2 strobe).
REQ-006 we  in  1  register write strobe; addr  in  5  SID register address; data_in  in  8  write data.
REQ-007 voice1_in, voice2_in, voice3_in, ext_in_in  in  12 each  voice and external sources.
REQ-008 sound_in  in  16  filter result.
REQ-009 Fc_lo, Fc_hi, Res_Filt, Mode_Vol  out  8 each  live filter configuration.
REQ-010 voice1, voice2, voice3, ext_in  out  12 each  per-sample voice snapshots to the filter.
REQ-011 input_valid  out  1  one-cycle filter start pulse.
REQ-012 sound_out  out  16  captured sample; sample_valid  out  1  one-cycle pulse per new sample.
REQ-013 overrun  out  1  sticky flag: sample request lost; dout  out  8  register readback.

Function
REQ-014 Writes with we=1 to addr 0x15/0x16/0x17/0x18 SHALL update shadow FC_LO/FC_HI/RES_FILT/MODE_VOL the next edge; other addresses ignored.
REQ-015 Live outputs Fc_lo..Mode_Vol SHALL change only on the edge entering ISSUE, copying shadows (atomic per sample); a write on that same edge SHALL land in the shadow and be committed next sample.
REQ-016 An 8-bit divider SHALL count tick pulses; the tick that brings it to SAMPLE_DIV-1 SHALL raise a request and wrap the divider to 0.
REQ-017 FSM states IDLE, ISSUE, WAIT, CAPTURE; IDLE->ISSUE on request or pending; ISSUE->WAIT always; WAIT->CAPTURE after FILT_LAT cycles; CAPTURE->IDLE.
REQ-018 On the edge entering ISSUE, voice1..ext_in SHALL latch the *_in inputs and hold them until the next ISSUE.
REQ-019 input_valid SHALL be 1 exactly during the ISSUE cycle (cycle T).
REQ-020 In CAPTURE (cycle T+FILT_LAT+1) sound_in SHALL be sampled; sound_out updates and sample_valid pulses in cycle T+FILT_LAT+2.
REQ-021 A request outside IDLE SHALL set pending; pending SHALL cause ISSUE immediately after CAPTURE->IDLE and clear on entering ISSUE.
REQ-022 A request while pending is already set SHALL set overrun; the extra request is dropped.
REQ-023 A request in IDLE coinciding with pending SHALL produce one ISSUE only.
REQ-024 sound_out SHALL hold its value between captures.

Reset
REQ-025 rst SHALL force state IDLE, divider 0, pending 0, overrun 0, all shadow and live config registers 0, voice snapshots 0, sound_out 0, input_valid 0, sample_valid 0, dout 0.
REQ-026 rst asserted mid-sample (ISSUE/WAIT/CAPTURE) SHALL abort it with no sample_valid pulse; operation resumes on the first request after rst deasserts.
REQ-027 overrun SHALL clear only on rst.

Configuration
REQ-028 Macro SID_FILT_READBACK_EN: when defined, dout SHALL be registered and show the shadow register for addr 0x15..0x18 one cycle after addr is presented, 0 for other addresses.
REQ-029 Without SID_FILT_READBACK_EN, dout SHALL be constant 0 and no readback logic synthesized.

Verification
REQ-030 SAMPLE_DIV=1, FILT_LAT=12: tick at cycle 0 -> input_valid at cycle 1; sound_in=0x1234 held -> sound_out=0x1234, sample_valid at cycle 15.
REQ-031 Write 0xAB to 0x16 during WAIT -> Fc_hi unchanged until next ISSUE, then 0xAB; write coinciding with ISSUE edge -> visible one sample later.
REQ-032 voice1_in changes 0x100->0x200 during WAIT -> voice1 stays 0x100 until next ISSUE.
REQ-033 Ticks at cycles 0, 5, 8 with SAMPLE_DIV=1 -> second sample issued right after first CAPTURE, third dropped, overrun=1 and stays 1 until rst.
REQ-034 SAMPLE_DIV=3: ticks every 4 cycles -> input_valid on every third tick only.
REQ-035 rst pulsed in WAIT -> no sample_valid, all outputs 0; with SID_FILT_READBACK_EN, write 0x5F to 0x17 then addr=0x17 -> dout=0x5F next cycle; without macro dout=0.

Source files
------------

// File: rtl/sid_filter_ctrl.sv
// SID filter sequencer: divides the tick stream into sample requests, snapshots voices and
// filter config, pulses the filter start and captures its result. SID_FILT_READBACK_EN adds shadow readback on dout.
module sid_filter_ctrl #(
    parameter int SAMPLE_DIV = 1,
    parameter int FILT_LAT   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [7:0]  data_in,
    input  logic [11:0] voice1_in,
    input  logic [11:0] voice2_in,
    input  logic [11:0] voice3_in,
    input  logic [11:0] ext_in_in,
    input  logic [15:0] sound_in,
    output logic [7:0]  Fc_lo,
    output logic [7:0]  Fc_hi,
    output logic [7:0]  Res_Filt,
    output logic [7:0]  Mode_Vol,
    output logic [11:0] voice1,
    output logic [11:0] voice2,
    output logic [11:0] voice3,
    output logic [11:0] ext_in,
    output logic        input_valid,
    output logic [15:0] sound_out,
    output logic        sample_valid,
    output logic        overrun,
    output logic [7:0]  dout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam logic [4:0] ADDR_FC_LO    = 5'h15;
    localparam logic [4:0] ADDR_FC_HI    = 5'h16;
    localparam logic [4:0] ADDR_RES_FILT = 5'h17;
    localparam logic [4:0] ADDR_MODE_VOL = 5'h18;
    localparam logic [7:0] DIV_LAST      = 8'(SAMPLE_DIV - 1);
    localparam logic [5:0] LAT_LAST      = 6'(FILT_LAT - 1);

    state_t      state_r;
    logic [7:0]  div_r;
    logic [5:0]  wait_cnt_r;
    logic        pending_r;
    logic        overrun_r;
    logic        input_valid_r;
    logic        sample_valid_r;
    logic [15:0] sound_out_r;
    logic        req_s;
    logic        issue_s;

    logic [7:0]  sh_fc_lo_r;
    logic [7:0]  sh_fc_hi_r;
    logic [7:0]  sh_res_filt_r;
    logic [7:0]  sh_mode_vol_r;
    logic [7:0]  fc_lo_r;
    logic [7:0]  fc_hi_r;
    logic [7:0]  res_filt_r;
    logic [7:0]  mode_vol_r;
    logic [11:0] voice1_r;
    logic [11:0] voice2_r;
    logic [11:0] voice3_r;
    logic [11:0] ext_in_r;

    // Sample request and ISSUE-entry decode
    always_comb begin
        req_s   = 1'b0;
        issue_s = 1'b0;
        if (tick && (div_r == DIV_LAST)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        if ((state_r == ST_IDLE) && (req_s || pending_r)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Tick divider, free-running regardless of sequencer state
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= 8'd0;
        end else if (tick) begin
            if (div_r == DIV_LAST) begin
                div_r <= 8'd0;
            end else begin
                div_r <= div_r + 8'd1;
            end
        end else begin
            div_r <= div_r;
        end
    end

    // Sample sequencer with registered strobes and captured result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            wait_cnt_r     <= 6'd0;
            pending_r      <= 1'b0;
            overrun_r      <= 1'b0;
            input_valid_r  <= 1'b0;
            sample_valid_r <= 1'b0;
            sound_out_r    <= 16'd0;
        end else begin
            input_valid_r  <= issue_s;
            sample_valid_r <= (state_r == ST_CAPTURE);

            // A request that finds a sample already queued is lost for good
            if (req_s && pending_r) begin
                overrun_r <= 1'b1;
            end
            if (issue_s) begin
                pending_r <= 1'b0;
            end else if (req_s && (state_r != ST_IDLE)) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_r    <= ST_WAIT;
                    wait_cnt_r <= 6'd0;
                end
                ST_WAIT: begin
                    if (wait_cnt_r == LAT_LAST) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 6'd1;
                    end
                end
                ST_CAPTURE: begin
                    state_r     <= ST_IDLE;
                    sound_out_r <= sound_in;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Shadow register writes and per-sample commit to the live config
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_fc_lo_r    <= 8'd0;
            sh_fc_hi_r    <= 8'd0;
            sh_res_filt_r <= 8'd0;
            sh_mode_vol_r <= 8'd0;
            fc_lo_r       <= 8'd0;
            fc_hi_r       <= 8'd0;
            res_filt_r    <= 8'd0;
            mode_vol_r    <= 8'd0;
        end else begin
            if (we) begin
                case (addr)
                    ADDR_FC_LO:    sh_fc_lo_r    <= data_in;
                    ADDR_FC_HI:    sh_fc_hi_r    <= data_in;
                    ADDR_RES_FILT: sh_res_filt_r <= data_in;
                    ADDR_MODE_VOL: sh_mode_vol_r <= data_in;
                    default: begin
                    end
                endcase
            end
            // Live copy reads the pre-edge shadow, so a same-edge write waits a sample
            if (issue_s) begin
                fc_lo_r    <= sh_fc_lo_r;
                fc_hi_r    <= sh_fc_hi_r;
                res_filt_r <= sh_res_filt_r;
                mode_vol_r <= sh_mode_vol_r;
            end
        end
    end

    // Voice snapshots held from one ISSUE to the next
    always_ff @(posedge clk) begin
        if (rst) begin
            voice1_r <= 12'd0;
            voice2_r <= 12'd0;
            voice3_r <= 12'd0;
            ext_in_r <= 12'd0;
        end else if (issue_s) begin
            voice1_r <= voice1_in;
            voice2_r <= voice2_in;
            voice3_r <= voice3_in;
            ext_in_r <= ext_in_in;
        end else begin
            voice1_r <= voice1_r;
            voice2_r <= voice2_r;
            voice3_r <= voice3_r;
            ext_in_r <= ext_in_r;
        end
    end

`ifdef SID_FILT_READBACK_EN
    logic [7:0] dout_r;

    // Registered shadow readback
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r <= 8'd0;
        end else begin
            case (addr)
                ADDR_FC_LO:    dout_r <= sh_fc_lo_r;
                ADDR_FC_HI:    dout_r <= sh_fc_hi_r;
                ADDR_RES_FILT: dout_r <= sh_res_filt_r;
                ADDR_MODE_VOL: dout_r <= sh_mode_vol_r;
                default:       dout_r <= 8'd0;
            endcase
        end
    end

    assign dout = dout_r;
`else
    assign dout = 8'd0;
`endif

    assign Fc_lo        = fc_lo_r;
    assign Fc_hi        = fc_hi_r;
    assign Res_Filt     = res_filt_r;
    assign Mode_Vol     = mode_vol_r;
    assign voice1       = voice1_r;
    assign voice2       = voice2_r;
    assign voice3       = voice3_r;
    assign ext_in       = ext_in_r;
    assign input_valid  = input_valid_r;
    assign sample_valid = sample_valid_r;
    assign sound_out    = sound_out_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_sid_filter_ctrl.sv
// Scoreboard bench for sid_filter_ctrl: expected ISSUE and sample events are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_sid_filter_ctrl;

    typedef struct {
        int          cyc;
        logic [11:0] v1, v2, v3, ve;
        logic [7:0]  fl, fh, rf, mv;
    } issue_t;

    typedef struct {
        int          cyc;
        logic [15:0] snd;
    } sample_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0, tick_b = 1'b0;
    logic        we = 1'b0, we_b = 1'b0;
    logic [4:0]  addr = 5'd0, addr_b = 5'd0;
    logic [7:0]  data_in = 8'd0, data_b = 8'd0;
    logic [11:0] v1_in = 12'd0, v2_in = 12'd0, v3_in = 12'd0, ve_in = 12'd0;
    logic [15:0] sound_in = 16'd0;

    logic [7:0]  fc_lo, fc_hi, res_filt, mode_vol, dout;
    logic [11:0] voice1, voice2, voice3, ext_in;
    logic        input_valid, sample_valid, overrun;
    logic [15:0] sound_out;

    logic [7:0]  fc_lo_b, fc_hi_b, res_filt_b, mode_vol_b, dout_b;
    logic [11:0] voice1_b, voice2_b, voice3_b, ext_in_b;
    logic        input_valid_b, sample_valid_b, overrun_b;
    logic [15:0] sound_out_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    issue_t  issue_q[$];
    sample_t sample_q[$];
    int      issue_b_q[$];
    issue_t  ei;
    sample_t es;
    int      eb;

    sid_filter_ctrl #(.SAMPLE_DIV(1), .FILT_LAT(12)) dut (
        .clk(clk), .rst(rst), .tick(tick), .we(we), .addr(addr), .data_in(data_in),
        .voice1_in(v1_in), .voice2_in(v2_in), .voice3_in(v3_in), .ext_in_in(ve_in),
        .sound_in(sound_in), .Fc_lo(fc_lo), .Fc_hi(fc_hi), .Res_Filt(res_filt),
        .Mode_Vol(mode_vol), .voice1(voice1), .voice2(voice2), .voice3(voice3),
        .ext_in(ext_in), .input_valid(input_valid), .sound_out(sound_out),
        .sample_valid(sample_valid), .overrun(overrun), .dout(dout)
    );

    sid_filter_ctrl #(.SAMPLE_DIV(3), .FILT_LAT(12)) dut_b (
        .clk(clk), .rst(rst), .tick(tick_b), .we(we_b), .addr(addr_b), .data_in(data_b),
        .voice1_in(v1_in), .voice2_in(v2_in), .voice3_in(v3_in), .ext_in_in(ve_in),
        .sound_in(sound_in), .Fc_lo(fc_lo_b), .Fc_hi(fc_hi_b), .Res_Filt(res_filt_b),
        .Mode_Vol(mode_vol_b), .voice1(voice1_b), .voice2(voice2_b), .voice3(voice3_b),
        .ext_in(ext_in_b), .input_valid(input_valid_b), .sound_out(sound_out_b),
        .sample_valid(sample_valid_b), .overrun(overrun_b), .dout(dout_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc_wait(1);
        tick = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        we = 1'b1;
        addr = a;
        data_in = d;
        cyc_wait(1);
        we = 1'b0;
    endtask

    task automatic push_issue(input int c, input logic [7:0] fl, input logic [7:0] fh,
                              input logic [7:0] rf, input logic [7:0] mv);
        issue_t e;
        e.cyc = c;
        e.v1 = v1_in; e.v2 = v2_in; e.v3 = v3_in; e.ve = ve_in;
        e.fl = fl; e.fh = fh; e.rf = rf; e.mv = mv;
        issue_q.push_back(e);
    endtask

    task automatic push_sample(input int c, input logic [15:0] s);
        sample_t e;
        e.cyc = c;
        e.snd = s;
        sample_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((issue_q.size() + sample_q.size() + issue_b_q.size()) != 0 && n < budget) begin
            cyc_wait(1);
            n++;
        end
        check("drain", issue_q.size() + sample_q.size() + issue_b_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fc_lo"}, fc_lo, 0);
        check({tag, "_fc_hi"}, fc_hi, 0);
        check({tag, "_res_filt"}, res_filt, 0);
        check({tag, "_mode_vol"}, mode_vol, 0);
        check({tag, "_voice1"}, voice1, 0);
        check({tag, "_ext_in"}, ext_in, 0);
        check({tag, "_sound_out"}, sound_out, 0);
        check({tag, "_input_valid"}, input_valid, 0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_dout"}, dout, 0);
    endtask

    // Monitor: every strobe from either DUT must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (input_valid) begin
                if (issue_q.size() == 0) begin
                    check("unexpected_input_valid", 32'd1, 32'd0);
                end else begin
                    ei = issue_q.pop_front();
                    check("issue_cycle", cyc, ei.cyc);
                    check("issue_voice1", voice1, ei.v1);
                    check("issue_voice2", voice2, ei.v2);
                    check("issue_voice3", voice3, ei.v3);
                    check("issue_ext_in", ext_in, ei.ve);
                    check("issue_fc_lo", fc_lo, ei.fl);
                    check("issue_fc_hi", fc_hi, ei.fh);
                    check("issue_res_filt", res_filt, ei.rf);
                    check("issue_mode_vol", mode_vol, ei.mv);
                end
            end
            if (sample_valid) begin
                if (sample_q.size() == 0) begin
                    check("unexpected_sample_valid", 32'd1, 32'd0);
                end else begin
                    es = sample_q.pop_front();
                    check("sample_cycle", cyc, es.cyc);
                    check("sample_sound_out", sound_out, es.snd);
                end
            end
            if (input_valid_b) begin
                if (issue_b_q.size() == 0) begin
                    check("unexpected_input_valid_div3", 32'd1, 32'd0);
                end else begin
                    eb = issue_b_q.pop_front();
                    check("issue_cycle_div3", cyc, eb);
                end
            end
        end
    end

    initial begin
        int t0;
        cyc_wait(3);
        rst = 1'b0;
        cyc_wait(1);
        check_all_zero("reset");
        check("reset_div3_sound_out", sound_out_b, 0);
        check("reset_div3_overrun", overrun_b, 0);

        // Shadows load but live config must wait for ISSUE
        do_write(5'h15, 8'h11);
        do_write(5'h16, 8'h22);
        do_write(5'h17, 8'h33);
        do_write(5'h18, 8'h44);
        do_write(5'h19, 8'hEE);
        check("live_before_issue", fc_hi, 0);

        // Basic sample: tick at t0 -> ISSUE t0+1, sample_valid t0+15
        v1_in = 12'h100; v2_in = 12'h222; v3_in = 12'h333; ve_in = 12'h444;
        sound_in = 16'h1234;
        t0 = cyc;
        push_issue(t0 + 1, 8'h11, 8'h22, 8'h33, 8'h44);
        push_sample(t0 + 15, 16'h1234);
        do_tick();
        cyc_wait(3);
        v1_in = 12'h200;
        do_write(5'h16, 8'hAB);
        check("wait_voice1_held", voice1, 12'h100);
        check("wait_fc_hi_held", fc_hi, 8'h22);
        wait_drain(40);
        cyc_wait(5);
        check("sound_out_hold", sound_out, 16'h1234);
        check("sample_valid_one_cycle", sample_valid, 0);

        // Write coinciding with the ISSUE edge lands one sample later
        sound_in = 16'h5678;
        t0 = cyc;
        push_issue(t0 + 1, 8'h11, 8'hAB, 8'h33, 8'h44);
        push_sample(t0 + 15, 16'h5678);
        tick = 1'b1; we = 1'b1; addr = 5'h16; data_in = 8'hCD;
        cyc_wait(1);
        tick = 1'b0; we = 1'b0;
        check("same_edge_write_live", fc_hi, 8'hAB);
        wait_drain(40);
        t0 = cyc;
        push_issue(t0 + 1, 8'h11, 8'hCD, 8'h33, 8'h44);
        push_sample(t0 + 15, 16'h5678);
        do_tick();
        wait_drain(40);

        // Ticks at 0, 5, 8: second queued behind first, third dropped
        sound_in = 16'h9ABC;
        t0 = cyc;
        push_issue(t0 + 1, 8'h11, 8'hCD, 8'h33, 8'h44);
        push_sample(t0 + 15, 16'h9ABC);
        push_issue(t0 + 16, 8'h11, 8'hCD, 8'h33, 8'h44);
        push_sample(t0 + 30, 16'h9ABC);
        do_tick();
        cyc_wait(4);
        check("overrun_before", overrun, 0);
        do_tick();
        cyc_wait(2);
        check("overrun_pending_only", overrun, 0);
        do_tick();
        check("overrun_set", overrun, 1);
        wait_drain(60);
        cyc_wait(20);
        check("overrun_sticky", overrun, 1);

        // Reset in WAIT aborts the sample and clears everything
        t0 = cyc;
        push_issue(t0 + 1, 8'h11, 8'hCD, 8'h33, 8'h44);
        do_tick();
        cyc_wait(4);
        rst = 1'b1;
        cyc_wait(1);
        rst = 1'b0;
        check_all_zero("abort");
        cyc_wait(25);
        wait_drain(5);

        // Readback of a shadow register
        do_write(5'h17, 8'h5F);
        addr = 5'h17;
        cyc_wait(1);
`ifdef SID_FILT_READBACK_EN
        check("readback_res_filt", dout, 8'h5F);
        addr = 5'h03;
        cyc_wait(1);
        check("readback_other", dout, 0);
`else
        check("readback_disabled", dout, 0);
`endif

        // Operation resumes after reset with freshly reset config
        sound_in = 16'h0F0F;
        t0 = cyc;
        push_issue(t0 + 1, 8'h00, 8'h00, 8'h5F, 8'h00);
        push_sample(t0 + 15, 16'h0F0F);
        do_tick();
        wait_drain(40);

        // Divide-by-3 instance: only every third tick issues
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                tick_b = 1'b1;
                if (k == 2) issue_b_q.push_back(cyc + 1);
                cyc_wait(1);
                tick_b = 1'b0;
                cyc_wait(3);
            end
            cyc_wait(20);
        end
        wait_drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
